mul_iter32: RTL
===============

# mul_iter32

Iterative 32-bit shift-and-add multiplier implementing the RV32M MUL, MULH, MULHSU and MULHU operations. It sits downstream of the 32-bit ripple adder and consumes its sum and carry once per cycle to build a 64-bit product. Its result feeds the execute-stage result mux. It uses a start/busy/done handshake so the pipeline can stall for the fixed multi-cycle latency.

## Interface

Parameters:
- XLEN, 32, operand and result width; only 32 is supported.

Ports:
- clk  in  1  single clock, rising-edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  request; sampled only in IDLE.
- op  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU (matches funct3[1:0]).
- rs1  in  32  multiplicand; signed for MULH and MULHSU.
- rs2  in  32  multiplier; signed for MULH only.
- busy  out  1  high from the cycle after start is accepted until DONE is left.
- done  out  1  one-cycle pulse; result is valid in this cycle.
- result  out  32  low word for MUL, high word otherwise; holds until the next accepted start.

## Operation

States: IDLE → CALC → SIGN → DONE → IDLE.

- **IDLE**
  - start=1 latches op.
  - Stores |rs1| into mcand and |rs2| into acc_lo; clears acc_hi.
  - Computes neg = sign(rs1) XOR sign(rs2), using signedness per op; neg is forced to 0 for MULHU.
  - Loads the iteration counter with 31 and goes to CALC.
- **CALC** (exactly 32 cycles), each cycle:
  - If acc_lo[0]=1, {c, s} = acc_hi + mcand via the adder with cin=0; otherwise {c, s} = {0, acc_hi}.
  - Then {acc_hi, acc_lo} ← {c, s, acc_lo[31:1]}.
  - The counter decrements; leave to SIGN when the counter is 0.
- **SIGN** (1 cycle): if neg, {acc_hi, acc_lo} ← ~{acc_hi, acc_lo} + 1 as a 64-bit two's complement.
- **DONE** (1 cycle):
  - done=1.
  - result ← acc_lo for MUL, acc_hi otherwise; result is registered, so it is valid in the same cycle as done.
  - Return to IDLE.

Rules:
- Magnitude of −2^31 is 0x80000000 treated as unsigned; no overflow handling is needed.
- No early termination: zero or one-valued operands still take the full latency.
- start while busy=1 or in DONE is ignored, with no queueing.
- The rs1, rs2 and op inputs are don't-care after the accept cycle.

## Timing

- Reset (rst_n=0 at a rising edge):
  - state=IDLE; busy=0, done=0, result=0.
  - acc, mcand and counter are cleared.
  - This applies from any state, including mid-CALC; the aborted operation produces no done.
- Start accepted at edge 0 gives:
  - busy=1 after edges 1..34;
  - SIGN after edge 33;
  - DONE (done=1, result valid) after edge 34;
  - IDLE, busy=0 after edge 35.
- Latency from start-accept to done is 34 cycles. Throughput is one operation per 35 cycles.
- A start asserted in the cycle immediately after the DONE cycle is accepted.
- There is no combinational path from start, rs1 or rs2 to any output.

## Structure

- Shared package mul_pkg:
  - mul_op_t enum (MUL, MULH, MULHSU, MULHU);
  - mul_state_t enum (IDLE, CALC, SIGN, DONE);
  - constants XLEN=32 and MUL_ITERS=32.
- One sub-module: the existing FullAdder_32 (a, b, cin → sum, cout), instantiated once for the per-cycle partial-product add.
- The 64-bit negate in SIGN is local logic and does not use the adder.

## Test plan

- MUL 7 × 6:
  - done pulses exactly 34 cycles after the start cycle with result=0x0000002A;
  - busy drops the following cycle.
- MULH 0x80000000 × 0x80000000 → 0x40000000.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; MUL on the same operands → 0x00000001.
- MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF; MULH 0xFFFFFFFD × 0x00000005 → 0xFFFFFFFF, and MUL on the same operands → 0xFFFFFFF1.
- Busy-start rejection:
  - start MUL 3 × 4, then pulse start with MUL 9 × 9 at cycle 5;
  - only one done occurs, with result=0x0000000C.
- Reset mid-CALC:
  - rst_n=0 at cycle 10 → busy=0, done=0, result=0 on the next edge, and no done appears;
  - a subsequent MUL 2 × 3 returns 0x00000006 after 34 cycles.

Source files
------------

// File: rtl/mul_pkg.sv
// mul_pkg: shared types and constants for the iterative multiplier.
//   mul_op_t    - RV32M multiply flavour, encoded as funct3[1:0]
//   mul_state_t - sequencer states of mul_iter32
//   XLEN, MUL_ITERS, CNT_W - datapath width, add/shift steps, counter width
//   abs_if()    - magnitude of a word when it is to be read as signed
package mul_pkg;

  localparam int XLEN      = 32;
  localparam int MUL_ITERS = 32;
  localparam int CNT_W     = $clog2(MUL_ITERS);

  typedef enum logic [1:0] {
    MUL    = 2'b00,
    MULH   = 2'b01,
    MULHSU = 2'b10,
    MULHU  = 2'b11
  } mul_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    SIGN = 2'b10,
    DONE = 2'b11
  } mul_state_t;

  // -2^31 maps to 0x80000000, which is the correct magnitude read unsigned.
  function automatic logic [XLEN-1:0] abs_if(input logic [XLEN-1:0] v,
                                             input logic            is_signed);
    return (is_signed && v[XLEN-1]) ? (~v + XLEN'(1)) : v;
  endfunction

endpackage

// File: rtl/mul_iter32_adder.sv
// FullAdder_32: 32-bit adder used for the per-step partial-product add.
//   a, b  in  32  addends
//   cin   in  1   carry in
//   sum   out 32  a + b + cin, low 32 bits
//   cout  out 1   carry out
module FullAdder_32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {32'b0, cin};

endmodule

// File: rtl/mul_iter32.sv
// mul_iter32: iterative shift-and-add multiplier for MUL/MULH/MULHSU/MULHU.
// Multiplies operand magnitudes over 32 add/shift steps, then fixes the sign
// of the 64-bit product in one extra step. Fixed 34-cycle start-to-done.
//   clk, rst_n  clock, synchronous active-low reset
//   start       request, sampled only in IDLE
//   op          00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   rs1, rs2    multiplicand / multiplier, only read in the accept cycle
//   busy        high while an operation is in flight (CALC..DONE)
//   done        one-cycle pulse, result valid in the same cycle
//   result      low word for MUL, high word otherwise; held until next done
//
// state | meaning
// IDLE  | waiting for start; operands and signs captured on accept
// CALC  | 32 add/shift steps over {acc_hi, acc_lo}
// SIGN  | negate the 64-bit product if exactly one operand was negative
// DONE  | result presented, done pulsed
module mul_iter32
  import mul_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  mul_state_t       state_q, state_d;
  mul_op_t          op_q, op_d;
  logic             neg_q, neg_d;
  logic [XLEN-1:0]  mcand_q, mcand_d;
  logic [XLEN-1:0]  acc_hi_q, acc_hi_d;
  logic [XLEN-1:0]  acc_lo_q, acc_lo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  result_q, result_d;

  mul_op_t          op_in;
  logic             rs1_signed, rs2_signed;
  logic             rs1_neg, rs2_neg;
  logic [XLEN-1:0]  add_b, add_sum;
  logic             add_cout;
  logic [2*XLEN-1:0] acc_neg, prod_final;

  assign op_in      = mul_op_t'(op);
  assign rs1_signed = (op_in == MULH) || (op_in == MULHSU);
  assign rs2_signed = (op_in == MULH);
  assign rs1_neg    = rs1_signed & rs1[XLEN-1];
  assign rs2_neg    = rs2_signed & rs2[XLEN-1];

  // Gating b to zero gives {c, s} = {0, acc_hi} without a separate path.
  assign add_b = acc_lo_q[0] ? mcand_q : '0;

  FullAdder_32 u_add (
    .a    (acc_hi_q),
    .b    (add_b),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  assign acc_neg    = ~{acc_hi_q, acc_lo_q} + (2*XLEN)'(1);
  assign prod_final = neg_q ? acc_neg : {acc_hi_q, acc_lo_q};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= MUL;
      neg_q    <= 1'b0;
      mcand_q  <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      mcand_q  <= mcand_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC:    if (cnt_q == '0) state_d = SIGN;
      SIGN:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    op_d     = op_q;
    neg_d    = neg_q;
    mcand_d  = mcand_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d     = op_in;
          neg_d    = rs1_neg ^ rs2_neg;
          mcand_d  = abs_if(rs1, rs1_signed);
          acc_lo_d = abs_if(rs2, rs2_signed);
          acc_hi_d = '0;
          cnt_d    = CNT_W'(MUL_ITERS - 1);
        end
      end
      CALC: begin
        // Multiplier bits drain out of acc_lo as product bits shift in.
        {acc_hi_d, acc_lo_d} = {add_cout, add_sum, acc_lo_q[XLEN-1:1]};
        cnt_d                = cnt_q - CNT_W'(1);
      end
      SIGN: begin
        {acc_hi_d, acc_lo_d} = prod_final;
        // Loaded here so result is already valid during DONE.
        result_d = (op_q == MUL) ? prod_final[XLEN-1:0]
                                 : prod_final[2*XLEN-1:XLEN];
      end
      default: ;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == DONE);
  end

  assign result = result_q;

endmodule
